// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO multiply/divide unit: opcodes, sequencer states
// and opcode classification helpers.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_e;

  function automatic logic is_mul(op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MSUB};
  endfunction

  function automatic logic is_div(op_e op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed(op_e op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Unsigned W-step datapath: shift-add multiply or restoring divide on magnitudes.
// Multiply leaves the 2W-bit product in {acc_hi,acc_lo}; divide leaves rem/quot.
module hilo_iter_core #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W-1:0] a_mag,
  input  logic [W-1:0] b_mag,
  output logic [W-1:0] acc_hi,
  output logic [W-1:0] acc_lo
);

  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_b;
  logic [W:0]   w_sum;
  logic [W:0]   w_shl;
  logic [W:0]   w_diff;

  always_comb begin
    w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shl  = {r_hi, r_lo[W-1]};
    w_diff = w_shl - {1'b0, r_b};
  end

  // Divide: bit W of the difference is the borrow, i.e. the trial subtract failed.
  always_ff @(posedge clk) begin
    if (load) begin
      r_hi <= '0;
      r_lo <= a_mag;
      r_b  <= b_mag;
    end else if (step) begin
      if (is_div) begin
        if (!w_diff[W]) begin
          r_hi <= w_diff[W-1:0];
          r_lo <= {r_lo[W-2:0], 1'b1};
        end else begin
          r_hi <= w_shl[W-1:0];
          r_lo <= {r_lo[W-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[W:1];
        r_lo <= {w_sum[0], r_lo[W-1:1]};
      end
    end
  end

  assign acc_hi = r_hi;
  assign acc_lo = r_lo;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative MULT/DIV sequencer (latency W+1).
// Define HILO_MADD_EN to enable MADD/MSUB accumulate; otherwise ops 6/7 are ignored.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         Clk,
  input  logic         Clr,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] rs,
  input  logic [W-1:0] rt,
  output logic [W-1:0] hi_out,
  output logic [W-1:0] lo_out,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_e         r_state, w_state_nxt;
  op_e            w_op, r_op;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_hi, r_lo, r_rs;
  logic           r_done, r_dz, r_neg_q, r_neg_r, r_bz;
  logic           w_idle, w_iter_op, w_accept, w_mthi, w_mtlo, w_sa, w_sb;
  logic [W-1:0]   w_a_mag, w_b_mag, w_acc_hi, w_acc_lo, w_q, w_r;
  logic [2*W-1:0] w_p, w_sp, w_fix;

  assign w_op   = op_e'(op);
  assign w_idle = (r_state == S_IDLE);

`ifdef HILO_MADD_EN
  assign w_iter_op = is_mul(w_op) || is_div(w_op);
`else
  assign w_iter_op = is_div(w_op) || (w_op inside {OP_MULT, OP_MULTU});
`endif

  assign w_accept = start && w_idle && w_iter_op;
  assign w_mthi   = start && w_idle && (w_op == OP_MTHI);
  assign w_mtlo   = start && w_idle && (w_op == OP_MTLO);
  assign w_sa     = is_signed(w_op) && rs[W-1];
  assign w_sb     = is_signed(w_op) && rt[W-1];
  assign w_a_mag  = w_sa ? -rs : rs;
  assign w_b_mag  = w_sb ? -rt : rt;

  hilo_iter_core #(.W(W)) u_core (
    .clk    (Clk),
    .load   (w_accept),
    .step   (r_state == S_RUN),
    .is_div (is_div(r_op)),
    .a_mag  (w_a_mag),
    .b_mag  (w_b_mag),
    .acc_hi (w_acc_hi),
    .acc_lo (w_acc_lo)
  );

  always_ff @(posedge Clk) begin
    if (Clr) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CW'(W - 1)) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sign fix-up: quotient/product take sign a^b, remainder takes the dividend's sign.
  always_comb begin
    w_p   = {w_acc_hi, w_acc_lo};
    w_sp  = r_neg_q ? -w_p : w_p;
    w_q   = r_neg_q ? -w_acc_lo : w_acc_lo;
    w_r   = r_neg_r ? -w_acc_hi : w_acc_hi;
    w_fix = w_sp;
    if (is_div(r_op)) begin
      w_fix = r_bz ? {r_rs, {W{1'b1}}} : {w_r, w_q};
    end
`ifdef HILO_MADD_EN
    else if (r_op == OP_MADD) begin
      w_fix = {r_hi, r_lo} + w_sp;
    end else if (r_op == OP_MSUB) begin
      w_fix = {r_hi, r_lo} - w_sp;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      r_hi    <= '0;
      r_lo    <= '0;
      r_rs    <= '0;
      r_cnt   <= '0;
      r_op    <= OP_MULT;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op    <= w_op;
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_rs    <= rs;
        r_bz    <= (rt == '0);
        r_cnt   <= '0;
        r_dz    <= 1'b0;
      end else if (r_state == S_RUN) begin
        r_cnt <= (r_cnt == CW'(W - 1)) ? '0 : r_cnt + CW'(1);
      end
      if (w_mthi) r_hi <= rs;
      if (w_mtlo) r_lo <= rs;
      if (r_state == S_FIX) begin
        {r_hi, r_lo} <= w_fix;
        r_done       <= 1'b1;
        r_dz         <= is_div(r_op) && r_bz;
      end
    end
  end

  assign hi_out   = r_hi;
  assign lo_out   = r_lo;
  assign busy     = !w_idle;
  assign done     = r_done;
  assign div_zero = r_dz;

endmodule
